// File: rtl/stream_buffer_if.sv
// ---------------------------------------------------------------------------
// stream_buffer_if
//   Groups the producer/consumer handshake and status signals of
//   stream_buffer into one bundle.
//
//   master modport (user side) drives : flush, data_1_en, data_1, rd_en
//   master modport observes           : data_2, data_2_valid, buffer_empty,
//                                       buffer_full, buffer_almost_full,
//                                       overflow, underflow, count
//   slave modport (buffer side) is the mirror image.
//
//   DATA_W and DEPTH must match the stream_buffer instance they connect to.
// ---------------------------------------------------------------------------
interface stream_buffer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              data_1_en;
  logic [DATA_W-1:0] data_1;
  logic              rd_en;
  logic [DATA_W-1:0] data_2;
  logic              data_2_valid;
  logic              buffer_empty;
  logic              buffer_full;
  logic              buffer_almost_full;
  logic              overflow;
  logic              underflow;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, data_1_en, data_1, rd_en,
    input  data_2, data_2_valid, buffer_empty, buffer_full,
           buffer_almost_full, overflow, underflow, count
  );

  modport slave (
    input  flush, data_1_en, data_1, rd_en,
    output data_2, data_2_valid, buffer_empty, buffer_full,
           buffer_almost_full, overflow, underflow, count
  );
endinterface

// File: rtl/stream_buffer.sv
// ---------------------------------------------------------------------------
// stream_buffer
//   Circular-buffer FIFO with a registered output word, occupancy count,
//   almost-full back-pressure and sticky overflow/underflow flags.
//
//   Ports:
//     clk_1 : single clock, all state changes on its rising edge
//     rst   : asynchronous active-high reset
//     bus   : stream_buffer_if.slave
//             flush              - synchronous clear (wins over requests)
//             data_1_en/data_1   - producer write request and word
//             rd_en              - consumer pop request
//             data_2/data_2_valid- popped word, valid for one cycle
//             buffer_empty/full/almost_full, overflow, underflow, count
//
//   Parameters: DATA_W word width, DEPTH (power of two, 2..256),
//               AF_LEVEL almost-full threshold (1..DEPTH-1).
// ---------------------------------------------------------------------------
module stream_buffer #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic           clk_1,
  input  logic           rst,
  stream_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_2_q, data_2_d;
  logic              data_2_valid_q, data_2_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic empty, full, wr_acc, rd_acc;

  // Status is decoded from the registered count only, so no input reaches
  // a flag or the count combinationally.
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Acceptance uses the occupancy before the edge: a write while full is
  // dropped even if a pop frees a slot in the same cycle, and a pop while
  // empty never bypasses a simultaneous write.
  assign wr_acc = bus.data_1_en && !full  && !bus.flush;
  assign rd_acc = bus.rd_en     && !empty && !bus.flush;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    data_2_d       = data_2_q;
    data_2_valid_d = 1'b0;
    overflow_d     = overflow_q;
    underflow_d    = underflow_q;

    if (bus.flush) begin
      // data_2 deliberately keeps its last value across a flush.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr_d       = rd_ptr_q + PTR_W'(1);
        data_2_d       = mem[rd_ptr_q];
        data_2_valid_d = 1'b1;
      end
      if (bus.data_1_en && full) begin
        overflow_d = 1'b1;
      end
      if (bus.rd_en && empty) begin
        underflow_d = 1'b1;
      end
      count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      data_2_q       <= '0;
      data_2_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      data_2_q       <= data_2_d;
      data_2_valid_q <= data_2_valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge clk_1) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= bus.data_1;
    end
  end

  assign bus.data_2             = data_2_q;
  assign bus.data_2_valid       = data_2_valid_q;
  assign bus.buffer_empty       = empty;
  assign bus.buffer_full        = full;
  assign bus.buffer_almost_full = (count_q >= AF_CNT);
  assign bus.overflow           = overflow_q;
  assign bus.underflow          = underflow_q;
  assign bus.count              = count_q;
endmodule

// File: tb/tb_stream_buffer.sv
// ---------------------------------------------------------------------------
// tb_stream_buffer
//   Directed bench for stream_buffer (DATA_W=16, DEPTH=8, AF_LEVEL=6).
//   Inputs change 1 ns after a rising edge; outputs are sampled at that
//   same point, i.e. showing the state registered at the edge just passed.
// ---------------------------------------------------------------------------
module tb_stream_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  stream_buffer_if #(.DATA_W(16), .DEPTH(8)) bus ();

  stream_buffer #(.DATA_W(16), .DEPTH(8), .AF_LEVEL(6)) dut (
    .clk_1 (clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [15:0] d, input logic rd, input logic fl);
    bus.data_1_en = en;
    bus.data_1    = d;
    bus.rd_en     = rd;
    bus.flush     = fl;
  endtask

  initial begin
    drive(1'b0, 16'h0, 1'b0, 1'b0);

    // Reset values while rst is held.
    #2;
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.buffer_empty), 1);
    check("rst_full", 32'(bus.buffer_full), 0);
    check("rst_afull", 32'(bus.buffer_almost_full), 0);
    check("rst_data2", 32'(bus.data_2), 0);
    check("rst_valid", 32'(bus.data_2_valid), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_udf", 32'(bus.underflow), 0);
    $display("reset: count=%0d empty=%0d", bus.count, bus.buffer_empty);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Fill 1..8, then drain.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 1'b0, 1'b0);
      tick();
      check("fill_count", 32'(bus.count), 32'(i));
      check("fill_afull", 32'(bus.buffer_almost_full), (i >= 6) ? 1 : 0);
      check("fill_full", 32'(bus.buffer_full), (i == 8) ? 1 : 0);
      $display("write 0x%04h -> count=%0d af=%0d full=%0d", i, bus.count, bus.buffer_almost_full, bus.buffer_full);
    end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      tick();
      check("drain_valid", 32'(bus.data_2_valid), 1);
      check("drain_data", 32'(bus.data_2), 32'(i));
      check("drain_count", 32'(bus.count), 32'(8 - i));
      $display("pop -> data_2=0x%04h valid=%0d count=%0d", bus.data_2, bus.data_2_valid, bus.count);
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    check("drain_idle_valid", 32'(bus.data_2_valid), 0);
    check("drain_empty", 32'(bus.buffer_empty), 1);
    check("drain_hold", 32'(bus.data_2), 8);
    check("drain_udf", 32'(bus.underflow), 0);

    // Overflow with a simultaneous pop.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(16'h10 + i), 1'b0, 1'b0);
      tick();
    end
    check("ovf_pre_full", 32'(bus.buffer_full), 1);
    drive(1'b1, 16'hBEEF, 1'b1, 1'b0);
    tick();
    check("ovf_flag", 32'(bus.overflow), 1);
    check("ovf_count", 32'(bus.count), 7);
    check("ovf_valid", 32'(bus.data_2_valid), 1);
    check("ovf_data", 32'(bus.data_2), 32'h10);
    $display("write 0xBEEF while full + pop -> ovf=%0d count=%0d data_2=0x%04h", bus.overflow, bus.count, bus.data_2);
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      tick();
      check("ovf_drain_data", 32'(bus.data_2), 32'(32'h10 + i));
      $display("pop -> data_2=0x%04h", bus.data_2);
    end
    check("ovf_drain_empty", 32'(bus.buffer_empty), 1);

    // Simultaneous write and pop while empty: no bypass.
    drive(1'b1, 16'h1234, 1'b1, 1'b0);
    tick();
    check("udf_flag", 32'(bus.underflow), 1);
    check("udf_valid", 32'(bus.data_2_valid), 0);
    check("udf_count", 32'(bus.count), 1);
    check("udf_hold", 32'(bus.data_2), 32'h17);
    $display("write 0x1234 + pop while empty -> udf=%0d count=%0d", bus.underflow, bus.count);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    check("udf_pop_valid", 32'(bus.data_2_valid), 1);
    check("udf_pop_data", 32'(bus.data_2), 32'h1234);
    check("udf_pop_count", 32'(bus.count), 0);
    $display("pop -> data_2=0x%04h", bus.data_2);

    // Flush clears sticky flags.
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    check("flush_ovf", 32'(bus.overflow), 0);
    check("flush_udf", 32'(bus.underflow), 0);

    // Wrap-around at steady occupancy 3.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(16'h100 + i), 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 16'(16'h103 + k), 1'b1, 1'b0);
      tick();
      check("wrap_count", 32'(bus.count), 3);
      check("wrap_valid", 32'(bus.data_2_valid), 1);
      check("wrap_data", 32'(bus.data_2), 32'(32'h100 + k));
      $display("write 0x%04h + pop -> data_2=0x%04h count=%0d", 16'h103 + k, bus.data_2, bus.count);
    end

    // Flush priority with 5 words held.
    drive(1'b1, 16'h200, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h201, 1'b0, 1'b0);
    tick();
    check("fp_pre_count", 32'(bus.count), 5);
    drive(1'b1, 16'hDEAD, 1'b1, 1'b1);
    tick();
    check("fp_count", 32'(bus.count), 0);
    check("fp_empty", 32'(bus.buffer_empty), 1);
    check("fp_ovf", 32'(bus.overflow), 0);
    check("fp_udf", 32'(bus.underflow), 0);
    check("fp_valid", 32'(bus.data_2_valid), 0);
    check("fp_hold", 32'(bus.data_2), 32'h113);
    $display("flush + write + pop -> count=%0d data_2=0x%04h", bus.count, bus.data_2);

    // Asynchronous reset between edges with 4 words held.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(16'h300 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("ar_pre_count", 32'(bus.count), 4);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("ar_count", 32'(bus.count), 0);
    check("ar_empty", 32'(bus.buffer_empty), 1);
    check("ar_data2", 32'(bus.data_2), 0);
    check("ar_valid", 32'(bus.data_2_valid), 0);
    check("ar_afull", 32'(bus.buffer_almost_full), 0);
    $display("async reset -> count=%0d empty=%0d", bus.count, bus.buffer_empty);
    #1;
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    check("ar_udf", 32'(bus.underflow), 1);
    check("ar_udf_valid", 32'(bus.data_2_valid), 0);
    check("ar_udf_count", 32'(bus.count), 0);
    $display("pop after reset -> udf=%0d", bus.underflow);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
